// File: rtl/shift_reg_sequencer_pkg.sv
// Shared definitions for the shift register sequencer and its datapath register.
// Contents:
//   WIDTH / CNT_W / CMPL_W : default datapath, repeat-count and completion-counter widths
//   OP_*                   : register select codes, also decoded by the datapath register
//   state_t                : sequencer FSM state encoding
package shift_reg_pkg;

    localparam int WIDTH  = 4;
    localparam int CNT_W  = 3;
    localparam int CMPL_W = 8;

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_SHR_IN = 3'b010;
    localparam logic [2:0] OP_SHL_IN = 3'b011;
    localparam logic [2:0] OP_ROT_R  = 3'b100;
    localparam logic [2:0] OP_ROT_B  = 3'b101;
    localparam logic [2:0] OP_ADD    = 3'b110;
    localparam logic [2:0] OP_CLR    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_SETTLE = 2'b10,
        ST_RESP   = 2'b11
    } state_t;

endpackage

// File: rtl/shift_reg_sequencer_if.sv
// Command / response channel between a host-side requester and the sequencer.
// Signals:
//   cmd_valid/cmd_ready : command handshake; cmd_op, cmd_data, cmd_count qualify it
//   rsp_valid/rsp_ready : response handshake; rsp_data carries the register contents
// Modports: master = requester side, slave = sequencer side.
interface shift_reg_sequencer_if #(
    parameter int WIDTH = shift_reg_pkg::WIDTH,
    parameter int CNT_W = shift_reg_pkg::CNT_W
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/shift_reg_sequencer_repeat_counter.sv
// srs_repeat_counter: loadable down-counter that times the ISSUE phase.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   load, load_val  : load the repeat count (already normalised to >= 1)
//   dec             : count down one step
//   last            : high while the current issue cycle is the final one
module srs_repeat_counter #(
    parameter int CNT_W = shift_reg_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] count_r;
    logic             last_r;

    // Count register; last is precomputed so it is a clean flop output in ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
            last_r  <= 1'b0;
        end else if (load) begin
            count_r <= load_val;
            last_r  <= (load_val == CNT_W'(1));
        end else if (dec) begin
            count_r <= count_r - CNT_W'(1);
            last_r  <= (count_r == CNT_W'(2));
        end else begin
            count_r <= count_r;
            last_r  <= last_r;
        end
    end

    assign last = last_r;

endmodule

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: accepts one command, drives the shift register select and
// data lines for N cycles, lets the register settle one cycle, then returns its
// contents on the response channel.
// Ports:
//   clk, reset : clock, asynchronous active-low reset (shared with the register)
//   host       : command/response channel (slave side)
//   sr_sel     : register select, HOLD outside the issue phase
//   sr_d_in    : register data input, zero outside the issue phase
//   sr_d_out   : register contents
//   busy       : high whenever the sequencer is not idle
//   cmpl_cnt   : completed response count, wraps
module shift_reg_sequencer
    import shift_reg_pkg::*;
#(
    parameter int WIDTH  = shift_reg_pkg::WIDTH,
    parameter int CNT_W  = shift_reg_pkg::CNT_W,
    parameter int CMPL_W = shift_reg_pkg::CMPL_W
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_reg_sequencer_if.slave host,
    output logic [2:0]           sr_sel,
    output logic [WIDTH-1:0]     sr_d_in,
    input  logic [WIDTH-1:0]     sr_d_out,
    output logic                 busy,
    output logic [CMPL_W-1:0]    cmpl_cnt
);

    state_t state_r;
    state_t state_nxt_s;

    logic              accept_s;
    logic              last_s;
    logic [CNT_W-1:0]  load_val_s;
    logic [2:0]        op_r;
    logic [WIDTH-1:0]  data_r;

    logic [2:0]        sel_r,       sel_nxt_s;
    logic [WIDTH-1:0]  d_in_r,      d_in_nxt_s;
    logic              rsp_valid_r, rsp_valid_nxt_s;
    logic [WIDTH-1:0]  rsp_data_r,  rsp_data_nxt_s;
    logic              busy_r,      busy_nxt_s;
    logic [CMPL_W-1:0] cmpl_r,      cmpl_nxt_s;

    assign accept_s   = (state_r == ST_IDLE) && host.cmd_valid;
    // A zero repeat count still performs one operation.
    assign load_val_s = (host.cmd_count == {CNT_W{1'b0}}) ? CNT_W'(1) : host.cmd_count;

    srs_repeat_counter #(.CNT_W(CNT_W)) u_repeat (
        .clk      (clk),
        .reset    (reset),
        .load     (accept_s),
        .load_val (load_val_s),
        .dec      (state_r == ST_ISSUE),
        .last     (last_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = host.cmd_valid ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:  state_nxt_s = last_s ? ST_SETTLE : ST_ISSUE;
            ST_SETTLE: state_nxt_s = ST_RESP;
            ST_RESP:   state_nxt_s = host.rsp_ready ? ST_IDLE : ST_RESP;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs, keyed on the next
    // state so each output is already correct in the first cycle of that state.
    always_comb begin
        sel_nxt_s  = OP_HOLD;
        d_in_nxt_s = {WIDTH{1'b0}};
        if (state_nxt_s == ST_ISSUE) begin
            if (accept_s) begin
                sel_nxt_s  = host.cmd_op;
                d_in_nxt_s = host.cmd_data;
            end else begin
                sel_nxt_s  = op_r;
                d_in_nxt_s = data_r;
            end
        end else begin
            sel_nxt_s  = OP_HOLD;
            d_in_nxt_s = {WIDTH{1'b0}};
        end

        if (state_r == ST_SETTLE) begin
            rsp_data_nxt_s = sr_d_out;
        end else begin
            rsp_data_nxt_s = rsp_data_r;
        end

        rsp_valid_nxt_s = (state_nxt_s == ST_RESP);
        busy_nxt_s      = (state_nxt_s != ST_IDLE);

        if ((state_r == ST_RESP) && host.rsp_ready) begin
            cmpl_nxt_s = cmpl_r + CMPL_W'(1);
        end else begin
            cmpl_nxt_s = cmpl_r;
        end
    end

    // Output registers and the latched command operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r        <= OP_HOLD;
            data_r      <= {WIDTH{1'b0}};
            sel_r       <= OP_HOLD;
            d_in_r      <= {WIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            cmpl_r      <= {CMPL_W{1'b0}};
        end else begin
            if (accept_s) begin
                op_r   <= host.cmd_op;
                data_r <= host.cmd_data;
            end else begin
                op_r   <= op_r;
                data_r <= data_r;
            end
            sel_r       <= sel_nxt_s;
            d_in_r      <= d_in_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            busy_r      <= busy_nxt_s;
            cmpl_r      <= cmpl_nxt_s;
        end
    end

    assign host.cmd_ready = (state_r == ST_IDLE);
    assign host.rsp_valid = rsp_valid_r;
    assign host.rsp_data  = rsp_data_r;
    assign sr_sel         = sel_r;
    assign sr_d_in        = d_in_r;
    assign busy           = busy_r;
    assign cmpl_cnt       = cmpl_r;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Testbench for shift_reg_sequencer: a behavioural 4-bit register sits on the
// sr_* lines, the driver pushes the expected result of each accepted command
// (from a closed-form model) into a scoreboard, and a monitor checks every
// cycle's outputs against the timing the scoreboard entry implies.
module tb_shift_reg_sequencer;
    import shift_reg_pkg::*;

    localparam int W = 4;

    typedef struct {
        int         t;
        int         n;
        logic [2:0] op;
        logic [3:0] d;
        logic [3:0] res;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    shift_reg_sequencer_if #(.WIDTH(W), .CNT_W(3)) bus ();

    logic [2:0]   sr_sel;
    logic [W-1:0] sr_d_in;
    logic [W-1:0] sr_q;
    logic         busy;
    logic [7:0]   cmpl_cnt;

    shift_reg_sequencer #(.WIDTH(W), .CNT_W(3), .CMPL_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .host     (bus),
        .sr_sel   (sr_sel),
        .sr_d_in  (sr_d_in),
        .sr_d_out (sr_q),
        .busy     (busy),
        .cmpl_cnt (cmpl_cnt)
    );

    // The datapath register the sequencer controls; serial input is d_in[0].
    always @(posedge clk or negedge reset) begin
        if (!reset) sr_q <= 4'd0;
        else begin
            case (sr_sel)
                OP_HOLD:   sr_q <= sr_q;
                OP_LOAD:   sr_q <= sr_d_in;
                OP_SHR_IN: sr_q <= {sr_d_in[0], sr_q[3:1]};
                OP_SHL_IN: sr_q <= {sr_q[2:0], sr_d_in[0]};
                OP_ROT_R:  sr_q <= {sr_q[0], sr_q[3:1]};
                OP_ROT_B:  sr_q <= {sr_q[2:0], sr_q[3]};
                OP_ADD:    sr_q <= sr_q + sr_d_in;
                default:   sr_q <= 4'd0;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_fail = 0;
    exp_t       sb[$];
    logic [3:0] ref_q = 4'd0;
    logic [7:0] exp_cmpl = 8'd0;
    int         last_hs = -1;
    int         ready_mode = 0;   // 0: ready high, 1: random, 2: ready low

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Register contents after applying op n times to q, in closed form.
    function automatic logic [3:0] ref_model(input logic [2:0] op, input logic [3:0] d,
                                             input int n, input logic [3:0] q);
        int v, k, r, m;
        m = 15;
        v = int'(q);
        k = (n > 4) ? 4 : n;
        r = n % 4;
        case (op)
            OP_LOAD:   v = int'(d);
            OP_SHR_IN: v = (v >> k) | (d[0] ? (m ^ (m >> k)) : 0);
            OP_SHL_IN: v = ((v << k) & m) | (d[0] ? ((1 << k) - 1) : 0);
            OP_ROT_R:  v = ((v >> r) | (v << (4 - r))) & m;
            OP_ROT_B:  v = ((v << r) | (v >> (4 - r))) & m;
            OP_ADD:    v = (v + n * int'(d)) % 16;
            OP_CLR:    v = 0;
            default:   v = v;
        endcase
        return v[3:0];
    endfunction

    // rsp_ready generator, updated just after each rising edge.
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: per-cycle output check against the outstanding scoreboard entry.
    initial begin : monitor
        exp_t e;
        bit   in_issue, exp_busy, exp_valid;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                exp_cmpl = 8'd0;
            end else begin
                if (sb.size() > 0) begin
                    e         = sb[0];
                    in_issue  = (cyc >= e.t + 1) && (cyc <= e.t + e.n);
                    exp_busy  = (cyc > e.t);
                    exp_valid = (cyc >= e.t + e.n + 2);
                end else begin
                    in_issue  = 1'b0;
                    exp_busy  = 1'b0;
                    exp_valid = 1'b0;
                end
                chk("sr_sel",    int'(sr_sel),        in_issue ? int'(e.op) : 0);
                chk("sr_d_in",   int'(sr_d_in),       in_issue ? int'(e.d) : 0);
                chk("busy",      int'(busy),          int'(exp_busy));
                chk("cmd_ready", int'(bus.cmd_ready), int'(!exp_busy));
                chk("rsp_valid", int'(bus.rsp_valid), int'(exp_valid));
                chk("cmpl_cnt",  int'(cmpl_cnt),      int'(exp_cmpl));
                if (exp_valid) chk("rsp_data", int'(bus.rsp_data), int'(e.res));
                if (exp_valid && bus.rsp_valid && bus.rsp_ready) begin
                    void'(sb.pop_front());
                    exp_cmpl = exp_cmpl + 8'd1;
                    last_hs  = cyc;
                end
            end
        end
    end

    // Offer one command; returns its accept cycle (or -1) just after the next edge.
    task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [2:0] cnt,
                        output int acc);
        int         n;
        logic [3:0] res;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.cmd_count = cnt;
        acc = -1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            chk("cmd_accept_timeout", int'(bus.cmd_ready), 1);
        end else begin
            n     = (cnt == 3'd0) ? 1 : int'(cnt);
            res   = ref_model(op, d, n, ref_q);
            ref_q = res;
            sb.push_back('{acc, n, op, d, res});
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_data  = 4'($urandom);
        bus.cmd_count = 3'($urandom);
    endtask

    // Wait (bounded) until every accepted command has been answered.
    task automatic drain();
        for (int w = 0; w < 400; w++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        #1;
    endtask

    // Assert reset away from a clock edge and check the asynchronous clear.
    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        ref_q = 4'd0;
        #1;
        chk("rst_sr_sel",    int'(sr_sel),        0);
        chk("rst_sr_d_in",   int'(sr_d_in),       0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data",  int'(bus.rsp_data),  0);
        chk("rst_cmpl_cnt",  int'(cmpl_cnt),      0);
        chk("rst_busy",      int'(busy),          0);
        chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int acc, acc2, prev;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 4'd0;
        bus.cmd_count = 3'd0;
        #2;
        do_reset();

        // Single LOAD, count 0 -> one issue cycle.
        send(OP_LOAD, 4'b1010, 3'd0, acc);
        drain();

        // LOAD then SHL_IN with serial 1, twice.
        send(OP_LOAD, 4'b0110, 3'd1, acc);
        send(OP_SHL_IN, 4'b0001, 3'd2, acc);
        drain();

        // LOAD then ADD three times, carry dropped.
        send(OP_LOAD, 4'b0011, 3'd0, acc);
        send(OP_ADD, 4'b0101, 3'd3, acc);
        drain();

        // Backpressure: hold rsp_ready low for 5 cycles while a command waits.
        ready_mode = 2;
        send(OP_LOAD, 4'b1001, 3'd1, acc);
        fork
            begin
                for (int w = 0; w < 50; w++) begin
                    @(negedge clk);
                    if (bus.rsp_valid) break;
                end
                repeat (5) @(posedge clk);
                ready_mode = 0;
            end
            send(OP_ROT_R, 4'b0000, 3'd1, acc2);
        join
        chk("accept_after_rsp", acc2, last_hs + 1);
        drain();

        // Reset in the second issue cycle of a count-5 ROT_R, then a normal LOAD.
        send(OP_ROT_R, 4'b0000, 3'd5, acc);
        @(posedge clk);
        #2;
        do_reset();
        send(OP_LOAD, 4'b0101, 3'd0, acc);
        drain();

        // 256 back-to-back CLR commands from a fresh reset.
        do_reset();
        prev = -1;
        for (int i = 0; i < 256; i++) begin
            send(OP_CLR, 4'($urandom), 3'd0, acc);
            if (i > 0) chk("clr_spacing", acc - prev, 4);
            prev = acc;
        end
        drain();
        chk("cmpl_wrap", int'(cmpl_cnt), 0);

        // Randomized commands with random response backpressure.
        ready_mode = 1;
        for (int i = 0; i < 80; i++) begin
            send(3'($urandom), 4'($urandom), 3'($urandom), acc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        ready_mode = 0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
